ramdp_be: RTL and testbench

- Parametrised successor to the team's single-clock true dual-port RAM.
- Adds per-byte write enables, a selectable read-during-write mode, and an optional output pipeline register.
- Adds deterministic write-collision arbitration and a hardware clear engine that zero-fills the array after reset or on request.
- Used as a generic on-chip buffer/scratchpad where both ports read and write and memory contents must be known after reset.

---
 rtl/ramdp_be.sv | 161 ++++++++++++++++
 tb/tb_ramdp_be.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramdp_be.sv
// Single-clock true dual-port RAM with byte-lane write enables, selectable
// read-during-write behaviour, optional output register and a zero-fill clear engine.
module ramdp_be #(
   parameter  int DW           = 32,
   parameter  int AW           = 10,
   parameter  int BW           = 8,
   parameter  int RDW_MODE     = 0,
   parameter  int OREG         = 0,
   parameter  int CLR_ON_RESET = 1,
   localparam int NB           = DW / BW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   output logic          busy,
   output logic          dbg_state,
   input  logic          en_a,
   input  logic [NB-1:0] we_a,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] din_a,
   output logic [DW-1:0] dout_a,
   output logic          vld_a,
   input  logic          en_b,
   input  logic [NB-1:0] we_b,
   input  logic [AW-1:0] addr_b,
   input  logic [DW-1:0] din_b,
   output logic [DW-1:0] dout_b,
   output logic          vld_b
);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   localparam state_t RST_STATE = (CLR_ON_RESET != 0) ? CLEAR : IDLE;

   state_t        state;
   logic [AW-1:0] cnt;
   logic          acc_a;
   logic          acc_b;
   logic          clr_we;
   logic [DW-1:0] rd_a;
   logic [DW-1:0] rd_b;

   logic [DW-1:0] mem [0:(2**AW)-1];

   assign busy      = (state == CLEAR);
   assign dbg_state = state;

   // The clear engine owns the array from the cycle clr is sampled, so a
   // port access coinciding with clr is dropped just like one during busy.
   assign acc_a  = en_a & ~busy & ~clr;
   assign acc_b  = en_b & ~busy & ~clr;
   assign clr_we = busy & ~clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RST_STATE;
         cnt   <= '0;
      end else if (clr) begin
         state <= CLEAR;
         cnt   <= '0;
      end else if (state == CLEAR) begin
         cnt <= cnt + 1'b1;
         if (cnt == {AW{1'b1}}) begin
            state <= IDLE;
         end
      end
   end

   // Port B lanes are written first so port A overrides them on a collision.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[cnt] <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (acc_b && we_b[i]) begin
               mem[addr_b][i*BW +: BW] <= din_b[i*BW +: BW];
            end
         end
         for (int i = 0; i < NB; i++) begin
            if (acc_a && we_a[i]) begin
               mem[addr_a][i*BW +: BW] <= din_a[i*BW +: BW];
            end
         end
      end
   end

   // Write-first only merges the reading port's own bytes; the other port's
   // same-cycle write is never visible to it.
   always_comb begin
      rd_a = mem[addr_a];
      rd_b = mem[addr_b];
      if (RDW_MODE != 0) begin
         for (int i = 0; i < NB; i++) begin
            if (we_a[i]) begin
               rd_a[i*BW +: BW] = din_a[i*BW +: BW];
            end
            if (we_b[i]) begin
               rd_b[i*BW +: BW] = din_b[i*BW +: BW];
            end
         end
      end
   end

   // vld_x is a one-cycle pulse marking the cycle dout_x takes a new word;
   // there is no back-pressure, and dout_x holds between pulses.
   if (OREG != 0) begin : g_oreg
      logic [DW-1:0] s1_a;
      logic [DW-1:0] s1_b;
      logic          s1_vld_a;
      logic          s1_vld_b;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1_a     <= '0;
            s1_b     <= '0;
            s1_vld_a <= 1'b0;
            s1_vld_b <= 1'b0;
            dout_a   <= '0;
            dout_b   <= '0;
            vld_a    <= 1'b0;
            vld_b    <= 1'b0;
         end else begin
            s1_vld_a <= acc_a;
            s1_vld_b <= acc_b;
            if (acc_a) begin
               s1_a <= rd_a;
            end
            if (acc_b) begin
               s1_b <= rd_b;
            end
            vld_a <= s1_vld_a;
            vld_b <= s1_vld_b;
            if (s1_vld_a) begin
               dout_a <= s1_a;
            end
            if (s1_vld_b) begin
               dout_b <= s1_b;
            end
         end
      end
   end else begin : g_noreg
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout_a <= '0;
            dout_b <= '0;
            vld_a  <= 1'b0;
            vld_b  <= 1'b0;
         end else begin
            vld_a <= acc_a;
            vld_b <= acc_b;
            if (acc_a) begin
               dout_a <= rd_a;
            end
            if (acc_b) begin
               dout_b <= rd_b;
            end
         end
      end
   end

endmodule

// File: tb/tb_ramdp_be.sv
// Bench for ramdp_be: two instances (read-first/no oreg and write-first/oreg)
// driven identically and checked against a word-level model every cycle.
module tb_ramdp_be;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int BW = 8;
   localparam int NB = DW / BW;
   localparam int DEPTH = 2**AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr = 1'b0;
   logic          en_a = 1'b0;
   logic [NB-1:0] we_a = '0;
   logic [AW-1:0] addr_a = '0;
   logic [DW-1:0] din_a = '0;
   logic          en_b = 1'b0;
   logic [NB-1:0] we_b = '0;
   logic [AW-1:0] addr_b = '0;
   logic [DW-1:0] din_b = '0;

   logic          u0_busy, u0_dbg, u0_vld_a, u0_vld_b;
   logic [DW-1:0] u0_dout_a, u0_dout_b;
   logic          u1_busy, u1_dbg, u1_vld_a, u1_vld_b;
   logic [DW-1:0] u1_dout_a, u1_dout_b;

   int n_checks = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ramdp_be #(.DW(DW), .AW(AW), .BW(BW), .RDW_MODE(0), .OREG(0), .CLR_ON_RESET(1)) u0 (
      .clk(clk), .rst(rst), .clr(clr), .busy(u0_busy), .dbg_state(u0_dbg),
      .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(u0_dout_a), .vld_a(u0_vld_a),
      .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(u0_dout_b), .vld_b(u0_vld_b)
   );

   ramdp_be #(.DW(DW), .AW(AW), .BW(BW), .RDW_MODE(1), .OREG(1), .CLR_ON_RESET(1)) u1 (
      .clk(clk), .rst(rst), .clr(clr), .busy(u1_busy), .dbg_state(u1_dbg),
      .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(u1_dout_a), .vld_a(u1_vld_a),
      .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(u1_dout_b), .vld_b(u1_vld_b)
   );

   task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] mdl_mem [DEPTH];
   int            clear_left;
   int            edge_n;
   logic [DW-1:0] exp_q0a[$], exp_q0b[$], exp_q1a[$], exp_q1b[$];
   int            due_q0a[$], due_q0b[$], due_q1a[$], due_q1b[$];
   logic [DW-1:0] ed0a = '0, ed0b = '0, ed1a = '0, ed1b = '0;
   logic          ev0a = 1'b0, ev0b = 1'b0, ev1a = 1'b0, ev1b = 1'b0;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                           input logic [NB-1:0] we);
      logic [DW-1:0] r;
      r = old;
      for (int i = 0; i < NB; i++) if (we[i]) r[i*BW +: BW] = d[i*BW +: BW];
      return r;
   endfunction

   task automatic model_reset();
      exp_q0a.delete(); exp_q0b.delete(); exp_q1a.delete(); exp_q1b.delete();
      due_q0a.delete(); due_q0b.delete(); due_q1a.delete(); due_q1b.delete();
      ed0a = '0; ed0b = '0; ed1a = '0; ed1b = '0;
      ev0a = 1'b0; ev0b = 1'b0; ev1a = 1'b0; ev1b = 1'b0;
      clear_left = DEPTH;
      edge_n = 0;
   endtask

   task automatic model_step();
      logic          busy_pre, ok_a, ok_b;
      logic [DW-1:0] old_a, old_b;
      edge_n++;
      busy_pre = (clear_left > 0);
      ok_a = en_a && !busy_pre && !clr;
      ok_b = en_b && !busy_pre && !clr;
      old_a = mdl_mem[addr_a];
      old_b = mdl_mem[addr_b];
      if (clr) clear_left = DEPTH;
      else if (busy_pre) begin
         mdl_mem[DEPTH - clear_left] = '0;
         clear_left--;
      end
      if (ok_b) mdl_mem[addr_b] = merge(mdl_mem[addr_b], din_b, we_b);
      if (ok_a) mdl_mem[addr_a] = merge(mdl_mem[addr_a], din_a, we_a);
      if (ok_a) begin
         exp_q0a.push_back(old_a); due_q0a.push_back(edge_n);
         exp_q1a.push_back(merge(old_a, din_a, we_a)); due_q1a.push_back(edge_n + 1);
      end
      if (ok_b) begin
         exp_q0b.push_back(old_b); due_q0b.push_back(edge_n);
         exp_q1b.push_back(merge(old_b, din_b, we_b)); due_q1b.push_back(edge_n + 1);
      end
      ev0a = 1'b0; ev0b = 1'b0; ev1a = 1'b0; ev1b = 1'b0;
      if (due_q0a.size() > 0 && due_q0a[0] == edge_n) begin
         ed0a = exp_q0a.pop_front(); void'(due_q0a.pop_front()); ev0a = 1'b1;
      end
      if (due_q0b.size() > 0 && due_q0b[0] == edge_n) begin
         ed0b = exp_q0b.pop_front(); void'(due_q0b.pop_front()); ev0b = 1'b1;
      end
      if (due_q1a.size() > 0 && due_q1a[0] == edge_n) begin
         ed1a = exp_q1a.pop_front(); void'(due_q1a.pop_front()); ev1a = 1'b1;
      end
      if (due_q1b.size() > 0 && due_q1b[0] == edge_n) begin
         ed1b = exp_q1b.pop_front(); void'(due_q1b.pop_front()); ev1b = 1'b1;
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("u0_busy", {31'b0, u0_busy}, {31'b0, clear_left > 0});
            chk("u1_busy", {31'b0, u1_busy}, {31'b0, clear_left > 0});
            chk("u0_vld_a", {31'b0, u0_vld_a}, {31'b0, ev0a});
            chk("u0_vld_b", {31'b0, u0_vld_b}, {31'b0, ev0b});
            chk("u1_vld_a", {31'b0, u1_vld_a}, {31'b0, ev1a});
            chk("u1_vld_b", {31'b0, u1_vld_b}, {31'b0, ev1b});
            chk("u0_dout_a", u0_dout_a, ed0a);
            chk("u0_dout_b", u0_dout_b, ed0b);
            chk("u1_dout_a", u1_dout_a, ed1a);
            chk("u1_dout_b", u1_dout_b, ed1b);
         end
      end
   end

   // ---------------- driver tasks ----------------
   logic [DW-1:0] r0a, r0b, r1a, r1b;
   logic          v0a, v0b, v1a, v1b, e1a, e1b;

   // One-cycle access on both ports; captures results of both instances at their latencies.
   task automatic access(input logic ea, input logic [NB-1:0] wa, input logic [AW-1:0] aa,
                         input logic [DW-1:0] da, input logic eb, input logic [NB-1:0] wb,
                         input logic [AW-1:0] ab, input logic [DW-1:0] db);
      en_a = ea; we_a = wa; addr_a = aa; din_a = da;
      en_b = eb; we_b = wb; addr_b = ab; din_b = db;
      @(negedge clk);
      en_a = 1'b0; we_a = '0; en_b = 1'b0; we_b = '0;
      r0a = u0_dout_a; v0a = u0_vld_a; r0b = u0_dout_b; v0b = u0_vld_b;
      e1a = u1_vld_a; e1b = u1_vld_b;
      @(negedge clk);
      r1a = u1_dout_a; v1a = u1_vld_a; r1b = u1_dout_b; v1b = u1_vld_b;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (!u0_busy) break;
         n++;
         @(negedge clk);
      end
   endtask

   int n_busy;
   int n_vld;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'b0, u0_busy}, 32'd1);
      chk("rst_dout_a", u0_dout_a, 32'h0);
      chk("rst_vld_b", {31'b0, u1_vld_b}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      count_busy(n_busy);
      chk("reset_sweep_len", n_busy, 32'd16);

      for (int i = 0; i < DEPTH; i++) begin
         access(1'b1, '0, AW'(i), '0, 1'b1, '0, AW'(DEPTH - 1 - i), '0);
         chk("clear_rd_u0a", r0a, 32'h0);
         chk("clear_rd_u1b", r1b, 32'h0);
         chk("clear_vld", {30'b0, v0a, v1b}, 32'd3);
      end

      access(1'b1, 4'b1111, 4'd3, 32'hAABBCCDD, 1'b0, '0, '0, '0);
      access(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, '0, '0, '0);
      access(1'b0, '0, '0, '0, 1'b1, 4'b0000, 4'd3, '0);
      chk("be_u0", r0b, 32'hAA22CC44);
      chk("be_u1", r1b, 32'hAA22CC44);
      chk("be_latency", {29'b0, v0b, e1b, v1b}, 32'd5);

      access(1'b1, 4'b1111, 4'd5, 32'h12345678, 1'b0, '0, '0, '0);
      access(1'b1, 4'b1100, 4'd5, 32'hFFFF0000, 1'b0, '0, '0, '0);
      chk("rdw_first_read", r0a, 32'h12345678);
      chk("rdw_first_write", r1a, 32'hFFFF5678);

      access(1'b1, 4'b0011, 4'd7, 32'h000000AA, 1'b1, 4'b1111, 4'd7, 32'hBBBBBBBB);
      access(1'b1, 4'b0000, 4'd7, '0, 1'b0, '0, '0, '0);
      chk("collision_u0", r0a, 32'hBBBB00AA);
      chk("collision_u1", r1a, 32'hBBBB00AA);

      access(1'b1, 4'b1111, 4'd9, 32'hDEADBEEF, 1'b1, 4'b0000, 4'd9, '0);
      chk("cross_u0", r0b, 32'h0);
      chk("cross_u1", r1b, 32'h0);
      access(1'b0, '0, '0, '0, 1'b1, 4'b0000, 4'd9, '0);
      chk("cross_after", r0b, 32'hDEADBEEF);

      // Restart a sweep 5 cycles in, with port A hammering a write throughout.
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (4) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_busy = 0;
      n_vld = 0;
      for (int k = 0; k < 40; k++) begin
         if (!u0_busy) break;
         n_busy++;
         en_a = 1'b1; we_a = 4'b1111; addr_a = 4'd2; din_a = 32'hFFFFFFFF;
         @(negedge clk);
         if (u0_vld_a || u1_vld_a) n_vld++;
      end
      en_a = 1'b0; we_a = '0;
      chk("clr_restart_len", n_busy, 32'd16);
      chk("busy_no_vld", n_vld, 32'd0);
      access(1'b1, 4'b0000, 4'd2, '0, 1'b1, 4'b0000, 4'd9, '0);
      chk("busy_no_write", r0a, 32'h0);
      chk("swept_9", r1b, 32'h0);

      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      count_busy(n_busy);
      chk("rst_mid_sweep_len", n_busy, 32'd16);

      for (int c = 0; c < 3000; c++) begin
         en_a = ($urandom_range(0, 3) != 0);
         en_b = ($urandom_range(0, 3) != 0);
         we_a = ($urandom_range(0, 2) == 0) ? '0 : NB'($urandom_range(0, 15));
         we_b = ($urandom_range(0, 2) == 0) ? '0 : NB'($urandom_range(0, 15));
         addr_a = AW'($urandom_range(0, DEPTH - 1));
         addr_b = ($urandom_range(0, 3) == 0) ? addr_a : AW'($urandom_range(0, DEPTH - 1));
         din_a = $urandom;
         din_b = $urandom;
         clr = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      en_a = 1'b0; en_b = 1'b0; we_a = '0; we_b = '0; clr = 1'b0;
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
